request_tracker: RTL and testbench
==================================

Name: request_tracker

Overview:
- Upstream stage of the per-state next-state controllers.
- Latches hall up, hall down and in-car button presses per absolute floor, and clears requests once they are served at an open door.
- Each cycle it re-expresses the pending requests relative to the car's current floor as 3-bit vectors: index 0 = current floor, 1 = any floor above, 2 = any floor below.
- These vectors drive the button_up / button_down / button_in inputs of the controller stage.

Parameters:
- NUM_FLOORS, 3, number of served floors; legal range 2..4.
- FLOOR_W, 2, width of the floor index; must satisfy 2^FLOOR_W >= NUM_FLOORS.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- press_up  input  NUM_FLOORS  one-cycle-or-longer hall-up press, bit f = floor f.
- press_down  input  NUM_FLOORS  hall-down press, bit f = floor f.
- press_in  input  NUM_FLOORS  in-car floor-select press, bit f = floor f.
- floor_cur  input  FLOOR_W  floor the car is at or last passed.
- at_floor  input  1  car is level with floor_cur (full position, not half).
- door_open  input  1  door currently open.
- req_up  output  NUM_FLOORS  latched hall-up requests (lamp drive).
- req_down  output  NUM_FLOORS  latched hall-down requests.
- req_in  output  NUM_FLOORS  latched in-car requests.
- button_up  output  3  relative hall-up view [here, above, below].
- button_down  output  3  relative hall-down view.
- button_in  output  3  relative in-car view.
- pending  output  1  any latched request exists.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high. All outputs are registered.
- Reset clears every output to 0. Reset asserted mid-operation drops all pending requests immediately, without waiting for a clock edge.
- Serve condition: serve = door_open & at_floor & (floor_cur < NUM_FLOORS).
- Per-bit request update, per floor f and per class (up, down, in):
  - Clear when serve and f == floor_cur.
  - Otherwise set on press.
  - Otherwise hold.
  - Clear beats a simultaneous press at the served floor: a press at an open door is already served.
- Unbuildable buttons are masked and never set: req_up[NUM_FLOORS-1] and req_down[0] are tied to 0.
- Press inputs are level-sampled each edge. A held press simply keeps re-setting the bit, except while that floor is being served.
- Relative view, computed from the next request values and the current floor_cur, then registered:
  - Index [0] = next_req[floor_cur].
  - Index [1] = OR of next_req[f] for all f > floor_cur.
  - Index [2] = OR of next_req[f] for all f < floor_cur.
- Latency: a press sampled at edge t is visible on req_* and button_* after edge t; a clear is equally visible after edge t.
- Invalid floor_cur (value >= NUM_FLOORS): no clearing, all button_* bits 0, req_* latching continues normally.
- Top floor: index [1] is always 0. Bottom floor: index [2] is always 0.
- pending = registered OR-reduce of all next_req bits.
- While at_floor = 0 (half position), nothing is cleared and the relative view still uses floor_cur.

Decomposition:
- Shared package:
  - constants REL_HERE = 0, REL_ABOVE = 1, REL_BELOW = 2;
  - default NUM_FLOORS;
  - direction encodings DIR_STOP = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10, used by the downstream controllers.
- One sub-module, request_relativizer: purely combinational mapping of one NUM_FLOORS request vector plus floor_cur into a 3-bit relative vector. It is instantiated three times (up, down, in).

Test Plan:
- Reset then idle: assert reset with press_in = 3'b111 → all outputs 0. Release; after the first edge, req_in = 3'b111 and pending = 1.
- Press above: floor_cur = 0, at_floor = 1, door_open = 0, press_in = 3'b100 for one cycle → req_in = 3'b100, button_in = 3'b010 after the edge, held thereafter.
- Serve clears: req_up = 3'b010 latched, floor_cur = 1, at_floor = 1, door_open = 1 → after one edge req_up = 0, button_up = 0, pending = 0.
- Simultaneous press and serve: floor_cur = 2, door_open = 1, at_floor = 1, press_down = 3'b100 and press_in = 3'b001 in the same cycle → req_down = 0 (clear wins), req_in = 3'b001, button_in = 3'b100.
- Masked buttons: press_up = 3'b100, press_down = 3'b001 → req_up = 0, req_down = 0, pending = 0.
- Half position and invalid floor:
  - at_floor = 0, door_open = 1, floor_cur = 1, req_in = 3'b010 → not cleared, button_in = 3'b001.
  - Then floor_cur = 3 → button_in = 0, req_in unchanged.

Source files
------------

// File: rtl/request_tracker_pkg.sv
// Shared constants and types for the request tracker and the downstream
// next-state controllers.
package request_tracker_pkg;

  localparam int NUM_FLOORS_DEF = 3;
  localparam int FLOOR_W_DEF    = 2;

  // Bit positions inside a relative request vector.
  localparam int REL_HERE  = 0;
  localparam int REL_ABOVE = 1;
  localparam int REL_BELOW = 2;
  localparam int REL_W     = 3;

  typedef logic [REL_W-1:0] rel_vec_t;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  function automatic logic floor_valid(input int floor_idx, input int num_floors);
    return (floor_idx < num_floors);
  endfunction

endpackage

// File: rtl/request_tracker_if.sv
// Button/position inputs and latched/relative request outputs of the tracker.
interface request_tracker_if
  import request_tracker_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) ();

  logic [NUM_FLOORS-1:0] press_up;
  logic [NUM_FLOORS-1:0] press_down;
  logic [NUM_FLOORS-1:0] press_in;
  logic [FLOOR_W-1:0]    floor_cur;
  logic                  at_floor;
  logic                  door_open;

  logic [NUM_FLOORS-1:0] req_up;
  logic [NUM_FLOORS-1:0] req_down;
  logic [NUM_FLOORS-1:0] req_in;
  rel_vec_t              button_up;
  rel_vec_t              button_down;
  rel_vec_t              button_in;
  logic                  pending;

  modport master (
    output press_up, press_down, press_in, floor_cur, at_floor, door_open,
    input  req_up, req_down, req_in, button_up, button_down, button_in, pending
  );

  modport slave (
    input  press_up, press_down, press_in, floor_cur, at_floor, door_open,
    output req_up, req_down, req_in, button_up, button_down, button_in, pending
  );

endinterface

// File: rtl/request_tracker_relativizer.sv
// Maps an absolute per-floor request vector onto [here, above, below] relative
// to the car's floor; an out-of-range floor yields an all-zero view.
module request_relativizer
  import request_tracker_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]    floor_cur,
  output rel_vec_t              rel
);

  always_comb begin
    rel = '0;
    if (floor_valid(int'(floor_cur), NUM_FLOORS)) begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (f == int'(floor_cur)) begin
          rel[REL_HERE] = rel[REL_HERE] | req[f];
        end else if (f > int'(floor_cur)) begin
          rel[REL_ABOVE] = rel[REL_ABOVE] | req[f];
        end else begin
          rel[REL_BELOW] = rel[REL_BELOW] | req[f];
        end
      end
    end
  end

endmodule

// File: rtl/request_tracker.sv
// Latches hall/car requests per floor, clears them when served at an open door,
// and publishes registered relative views for the next-state controllers.
module request_tracker
  import request_tracker_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  request_tracker_if.slave   bus
);

  // No hall-up button on the top floor, no hall-down button on the bottom one.
  localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DOWN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  logic                  serve;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] nxt_up;
  logic [NUM_FLOORS-1:0] nxt_down;
  logic [NUM_FLOORS-1:0] nxt_in;
  rel_vec_t              rel_up;
  rel_vec_t              rel_down;
  rel_vec_t              rel_in;

  logic [NUM_FLOORS-1:0] req_up_p0;
  logic [NUM_FLOORS-1:0] req_down_p0;
  logic [NUM_FLOORS-1:0] req_in_p0;
  rel_vec_t              button_up_p0;
  rel_vec_t              button_down_p0;
  rel_vec_t              button_in_p0;
  logic                  pending_p0;

  // Clear outranks a simultaneous press: a press at the open door is already served.
  always_comb begin
    serve      = bus.door_open & bus.at_floor &
                 floor_valid(int'(bus.floor_cur), NUM_FLOORS);
    clear_mask = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (serve && (f == int'(bus.floor_cur))) begin
        clear_mask[f] = 1'b1;
      end
    end
    nxt_up   = (req_up_p0   | bus.press_up)   & ~clear_mask & UP_MASK;
    nxt_down = (req_down_p0 | bus.press_down) & ~clear_mask & DOWN_MASK;
    nxt_in   = (req_in_p0   | bus.press_in)   & ~clear_mask;
  end

  request_relativizer #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_rel_up (
    .req       (nxt_up),
    .floor_cur (bus.floor_cur),
    .rel       (rel_up)
  );

  request_relativizer #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_rel_down (
    .req       (nxt_down),
    .floor_cur (bus.floor_cur),
    .rel       (rel_down)
  );

  request_relativizer #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_rel_in (
    .req       (nxt_in),
    .floor_cur (bus.floor_cur),
    .rel       (rel_in)
  );

  // Stage p0: latched requests and their relative views.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_up_p0      <= '0;
      req_down_p0    <= '0;
      req_in_p0      <= '0;
      button_up_p0   <= '0;
      button_down_p0 <= '0;
      button_in_p0   <= '0;
      pending_p0     <= 1'b0;
    end else begin
      req_up_p0      <= nxt_up;
      req_down_p0    <= nxt_down;
      req_in_p0      <= nxt_in;
      button_up_p0   <= rel_up;
      button_down_p0 <= rel_down;
      button_in_p0   <= rel_in;
      pending_p0     <= |{nxt_up, nxt_down, nxt_in};
    end
  end

  assign bus.req_up      = req_up_p0;
  assign bus.req_down    = req_down_p0;
  assign bus.req_in      = req_in_p0;
  assign bus.button_up   = button_up_p0;
  assign bus.button_down = button_down_p0;
  assign bus.button_in   = button_in_p0;
  assign bus.pending     = pending_p0;

endmodule

// File: tb/tb_request_tracker.sv
// Randomized bench for request_tracker with a per-floor behavioural model and
// a few directed scenarios pinned to literal values.
module tb_request_tracker;

  localparam int NF = 3;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  request_tracker_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  request_tracker #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic [NF-1:0] m_up, m_down, m_in;
  logic [2:0]    m_bu, m_bd, m_bi;
  logic          m_pend;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Floor being served this cycle, or -1 when nothing is served.
  function automatic int served_floor();
    if (bus.door_open === 1'b1 && bus.at_floor === 1'b1 && int'(bus.floor_cur) < NF)
      return int'(bus.floor_cur);
    return -1;
  endfunction

  // One class of buttons: missing_floor is the floor lacking that button (-1: none).
  function automatic logic [NF-1:0] model_next(input logic [NF-1:0] cur,
                                               input logic [NF-1:0] press,
                                               input int missing_floor);
    logic [NF-1:0] r;
    int sf;
    sf = served_floor();
    for (int f = 0; f < NF; f++) begin
      if (f == missing_floor)  r[f] = 1'b0;
      else if (f == sf)        r[f] = 1'b0;
      else if (press[f])       r[f] = 1'b1;
      else                     r[f] = cur[f];
    end
    return r;
  endfunction

  // Relative view: [0] a request at the car's floor, [1] one above, [2] one below.
  function automatic logic [2:0] rel_of(input logic [NF-1:0] v, input int fc);
    logic [2:0] r;
    r = 3'b000;
    if (fc >= NF) return r;
    for (int f = 0; f < NF; f++) begin
      if (v[f]) begin
        if (f == fc)     r[0] = 1'b1;
        else if (f > fc) r[1] = 1'b1;
        else             r[2] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_up <= '0; m_down <= '0; m_in <= '0;
      m_bu <= '0; m_bd <= '0; m_bi <= '0;
      m_pend <= 1'b0;
    end else begin
      m_up   <= model_next(m_up,   bus.press_up,   NF - 1);
      m_down <= model_next(m_down, bus.press_down, 0);
      m_in   <= model_next(m_in,   bus.press_in,   -1);
      m_bu   <= rel_of(model_next(m_up,   bus.press_up,   NF - 1), int'(bus.floor_cur));
      m_bd   <= rel_of(model_next(m_down, bus.press_down, 0),      int'(bus.floor_cur));
      m_bi   <= rel_of(model_next(m_in,   bus.press_in,   -1),     int'(bus.floor_cur));
      m_pend <= |{model_next(m_up, bus.press_up, NF - 1),
                  model_next(m_down, bus.press_down, 0),
                  model_next(m_in, bus.press_in, -1)};
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_req_up",      bus.req_up,      m_up);
      chk("cyc_req_down",    bus.req_down,    m_down);
      chk("cyc_req_in",      bus.req_in,      m_in);
      chk("cyc_button_up",   bus.button_up,   m_bu);
      chk("cyc_button_down", bus.button_down, m_bd);
      chk("cyc_button_in",   bus.button_in,   m_bi);
      chk("cyc_pending",     bus.pending,     m_pend);
    end
  end

  task automatic setin(input logic [NF-1:0] up, input logic [NF-1:0] dn,
                       input logic [NF-1:0] inn, input logic [FW-1:0] fc,
                       input logic at, input logic door);
    bus.press_up   = up;
    bus.press_down = dn;
    bus.press_in   = inn;
    bus.floor_cur  = fc;
    bus.at_floor   = at;
    bus.door_open  = door;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset between edges, clear of the negedge compare.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    setin('0, '0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    bus.press_in = 3'b111;
    #1 check_en = 1'b1;

    @(negedge clk);
    chk("rst_req_in",    bus.req_in,    8'h0);
    chk("rst_button_in", bus.button_in, 8'h0);
    chk("rst_pending",   bus.pending,   8'h0);
    rst = 1'b0;
    step();
    chk("idle_req_in",  bus.req_in,  8'h7);
    chk("idle_pending", bus.pending, 8'h1);

    rst = 1'b1;
    #1;
    chk("async_req_in",  bus.req_in,  8'h0);
    chk("async_pending", bus.pending, 8'h0);
    #1 rst = 1'b0;

    pulse_reset();
    setin('0, '0, 3'b100, 2'd0, 1'b1, 1'b0);
    step();
    chk("above_req_in",    bus.req_in,    8'h4);
    chk("above_button_in", bus.button_in, 8'h2);
    setin('0, '0, '0, 2'd0, 1'b1, 1'b0);
    step();
    chk("above_hold_req_in",    bus.req_in,    8'h4);
    chk("above_hold_button_in", bus.button_in, 8'h2);

    pulse_reset();
    setin(3'b010, '0, '0, 2'd1, 1'b1, 1'b0);
    step();
    chk("serve_pre_req_up",    bus.req_up,    8'h2);
    chk("serve_pre_button_up", bus.button_up, 8'h1);
    setin('0, '0, '0, 2'd1, 1'b1, 1'b1);
    step();
    chk("serve_req_up",    bus.req_up,    8'h0);
    chk("serve_button_up", bus.button_up, 8'h0);
    chk("serve_pending",   bus.pending,   8'h0);

    pulse_reset();
    setin('0, 3'b100, 3'b001, 2'd2, 1'b1, 1'b1);
    step();
    chk("simul_req_down",  bus.req_down,  8'h0);
    chk("simul_req_in",    bus.req_in,    8'h1);
    chk("simul_button_in", bus.button_in, 8'h4);

    pulse_reset();
    setin(3'b100, 3'b001, '0, 2'd0, 1'b0, 1'b0);
    step();
    chk("mask_req_up",   bus.req_up,   8'h0);
    chk("mask_req_down", bus.req_down, 8'h0);
    chk("mask_pending",  bus.pending,  8'h0);

    pulse_reset();
    setin('0, '0, 3'b010, 2'd1, 1'b0, 1'b1);
    step();
    setin('0, '0, '0, 2'd1, 1'b0, 1'b1);
    step();
    chk("half_req_in",    bus.req_in,    8'h2);
    chk("half_button_in", bus.button_in, 8'h1);
    setin('0, '0, '0, 2'd3, 1'b1, 1'b1);
    step();
    chk("inval_req_in",    bus.req_in,    8'h2);
    chk("inval_button_in", bus.button_in, 8'h0);
    chk("inval_pending",   bus.pending,   8'h1);

    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [FW-1:0] fc;
      fc = bus.floor_cur;
      if ($urandom_range(0, 3) == 0) fc = FW'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) pulse_reset();
      setin(NF'($urandom & $urandom & $urandom),
            NF'($urandom & $urandom & $urandom),
            NF'($urandom & $urandom & $urandom),
            fc,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
      step();
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
